// File: rtl/glip_arb_pkg.sv
// Shared types and helpers for the GLIP fifo_out arbiter.
package glip_arb_pkg;

    // Arbiter FSM states: wait for a request, send the header word, stream the packet.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a requester index; at least one bit even for tiny N.
    function automatic int calc_idw(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/glip_rr_pick.sv
// Combinational round-robin picker: returns the first requester after ptr
// (wrapping modulo N) that has its request bit set.
module glip_rr_pick
    import glip_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    int cand;

    // Scan ptr+1 .. ptr+N and keep the first hit.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/glip_out_arbiter.sv
// Round-robin arbiter sharing the host-bound GLIP fifo_out channel between N
// requesters. Grant is held for a whole packet; an optional header word
// carrying the channel id precedes each packet. A packet longer than
// MAX_BEATS is cut and the remainder competes again as a new packet.
//
// Handshake: a beat moves on a side when valid and ready are both high in the
// same cycle. Ready never depends on valid of the same side.
module glip_out_arbiter
    import glip_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N         = 4,
    parameter bit HDR_EN    = 1'b1,
    parameter int MAX_BEATS = 256,
    localparam int IDW      = calc_idw(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   req_data,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = clog2(MAX_BEATS + 1);

    arb_state_t       state, state_n;
    logic [IDW-1:0]   grant_n;
    logic [CW-1:0]    beat_cnt, cnt_n;
    logic [WIDTH-1:0] odata_n;
    logic             ovalid_n;
    logic             err_n;

    logic             load;
    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] hdr_word;
    logic             xfer;

    // Output register can take a new word when empty or draining this cycle.
    assign load = !out_valid || out_ready;
    assign busy = (state != ST_IDLE);
    assign xfer = (state == ST_DATA) && load && sel_valid;

    glip_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (grant_id),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Select the granted requester's beat and header word.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_data  = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
        hdr_word              = '0;
        hdr_word[IDW-1:0]     = grant_id;
    end

    // Only the granted requester sees ready, and only in DATA when the output can load.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if ((state == ST_DATA) && load && (grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Next-state, pointer, beat counter and output register contents.
    always_comb begin
        state_n  = state;
        grant_n  = grant_id;
        cnt_n    = beat_cnt;
        odata_n  = out_data;
        ovalid_n = out_valid;
        err_n    = 1'b0;
        // A drained word leaves the register empty unless refilled below.
        if (load) begin
            ovalid_n = 1'b0;
        end
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_n = pick_idx;
                    state_n = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                // Header goes out regardless of whether the requester is still valid.
                if (load) begin
                    odata_n  = hdr_word;
                    ovalid_n = 1'b1;
                    state_n  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    odata_n  = sel_data;
                    ovalid_n = 1'b1;
                    if (sel_last) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
                        // Beat budget spent without last: release and flag it.
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register; reset puts the pointer on N-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_id  <= IDW'(N - 1);
            beat_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            grant_id  <= grant_n;
            beat_cnt  <= cnt_n;
            out_data  <= odata_n;
            out_valid <= ovalid_n;
            err       <= err_n;
        end
    end

endmodule
